// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared icodes, register IDs, stat codes and widths for the fetch stage
package fetch_stage_pkg;

    localparam int BYTE = 8;
    localparam int WORD = 32;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [BYTE-1:0] RNONE = 8'h0F;
    localparam logic [BYTE-1:0] RESP  = 8'h04;

    typedef enum logic [BYTE-1:0] {
        STAT_AOK = 8'h01,
        STAT_HLT = 8'h02,
        STAT_INS = 8'h04
    } stat_e;

    function automatic logic need_regids(input logic [3:0] icode);
        return icode inside {I_RRMOVL, I_IRMOVL, I_RMMOVL, I_MRMOVL, I_OPL, I_PUSHL, I_POPL};
    endfunction

    function automatic logic need_valc(input logic [3:0] icode);
        return icode inside {I_IRMOVL, I_RMMOVL, I_MRMOVL, I_JXX, I_CALL};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory port between fetch and imem
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [WORD-1:0]   imem_addr_o;
    logic [6*BYTE-1:0] imem_data_i;
    logic              imem_ready_i;

    modport master (output imem_addr_o, input imem_data_i, input imem_ready_i);
    modport slave  (input imem_addr_o, output imem_data_i, output imem_ready_i);
endinterface

// File: rtl/fetch_split.sv
// rtl/fetch_split.sv - pulls icode/ifun/rA/rB/valC out of six raw instruction bytes
module fetch_split
    import fetch_stage_pkg::*;
(
    input  logic [6*BYTE-1:0] data_i,
    output logic [BYTE-1:0]   icode_o,
    output logic [BYTE-1:0]   ifun_o,
    output logic [BYTE-1:0]   ra_o,
    output logic [BYTE-1:0]   rb_o,
    output logic [WORD-1:0]   valc_o,
    output logic              need_regids_o,
    output logic              need_valc_o
);

    logic [3:0] icode4;

    always_comb begin
        icode4        = data_i[7:4];
        icode_o       = {4'h0, data_i[7:4]};
        ifun_o        = {4'h0, data_i[3:0]};
        need_regids_o = need_regids(icode4);
        need_valc_o   = need_valc(icode4);
        ra_o          = RNONE;
        rb_o          = RNONE;
        valc_o        = '0;
        if (need_regids_o) begin
            ra_o = {4'h0, data_i[15:12]};
            rb_o = {4'h0, data_i[11:8]};
        end
        // Constant sits after the register byte when there is one.
        if (need_valc_o) begin
            valc_o = need_regids_o ? data_i[47:16] : data_i[39:8];
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC select, predicted PC and halt tracking around the byte splitter
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              F_stall_i,
    input  logic [BYTE-1:0]   M_icode_i,
    input  logic              M_Cnd_i,
    input  logic [WORD-1:0]   M_valA_i,
    input  logic [BYTE-1:0]   W_icode_i,
    input  logic [WORD-1:0]   W_valM_i,
    fetch_stage_if.master     imem,
    output logic [BYTE-1:0]   f_icode_o,
    output logic [BYTE-1:0]   f_ifun_o,
    output logic [BYTE-1:0]   f_rA_o,
    output logic [BYTE-1:0]   f_rB_o,
    output logic [BYTE-1:0]   f_dstE_o,
    output logic [BYTE-1:0]   f_dstM_o,
    output logic [BYTE-1:0]   f_stat_o,
    output logic [WORD-1:0]   f_valC_o,
    output logic [WORD-1:0]   f_valP_o
);

    logic [WORD-1:0] pred_pc_q, pred_pc_d;
    logic            halted_q, halted_d;

    logic [WORD-1:0] f_pc;
    logic            mispredict, ret_redirect, redirect, eff_halted, bubble;
    logic [BYTE-1:0] sp_icode, sp_ifun, sp_ra, sp_rb;
    logic [WORD-1:0] sp_valc, valp, pred_pc_next;
    logic            sp_need_regids, sp_need_valc;
    logic [BYTE-1:0] dst_e, dst_m;
    stat_e           stat;

    fetch_split u_split (
        .data_i        (imem.imem_data_i),
        .icode_o       (sp_icode),
        .ifun_o        (sp_ifun),
        .ra_o          (sp_ra),
        .rb_o          (sp_rb),
        .valc_o        (sp_valc),
        .need_regids_o (sp_need_regids),
        .need_valc_o   (sp_need_valc)
    );

    always_comb begin
        mispredict   = (M_icode_i == {4'h0, I_JXX}) && !M_Cnd_i;
        ret_redirect = (W_icode_i == {4'h0, I_RET});
        redirect     = mispredict || ret_redirect;
        f_pc         = mispredict ? M_valA_i : (ret_redirect ? W_valM_i : pred_pc_q);
        // A redirect overrides a pending halt in the very cycle it arrives.
        eff_halted   = halted_q && !redirect;
        bubble       = rst || eff_halted || (!F_stall_i && !imem.imem_ready_i);

        valp = f_pc + 32'd1 + (sp_need_regids ? 32'd1 : 32'd0) + (sp_need_valc ? 32'd4 : 32'd0);

        if (sp_icode == {4'h0, I_HALT})  stat = STAT_HLT;
        else if (sp_icode > {4'h0, I_POPL}) stat = STAT_INS;
        else                              stat = STAT_AOK;

        dst_e = RNONE;
        dst_m = RNONE;
        case (sp_icode[3:0])
            I_RRMOVL, I_IRMOVL, I_OPL:       dst_e = sp_rb;
            I_CALL, I_RET, I_PUSHL, I_POPL:  dst_e = RESP;
            default:                         dst_e = RNONE;
        endcase
        if (sp_icode[3:0] == I_MRMOVL || sp_icode[3:0] == I_POPL) dst_m = sp_ra;
        if (stat == STAT_INS) begin
            dst_e = RNONE;
            dst_m = RNONE;
        end

        pred_pc_next = (sp_icode[3:0] == I_JXX || sp_icode[3:0] == I_CALL) ? sp_valc : valp;

        if (bubble) begin
            f_icode_o = {4'h0, I_NOP};
            f_ifun_o  = '0;
            f_rA_o    = RNONE;
            f_rB_o    = RNONE;
            f_dstE_o  = RNONE;
            f_dstM_o  = RNONE;
            f_valC_o  = '0;
            f_valP_o  = rst ? '0 : f_pc;
            f_stat_o  = STAT_AOK;
        end else begin
            f_icode_o = sp_icode;
            f_ifun_o  = sp_ifun;
            f_rA_o    = sp_ra;
            f_rB_o    = sp_rb;
            f_dstE_o  = dst_e;
            f_dstM_o  = dst_m;
            f_valC_o  = sp_valc;
            f_valP_o  = valp;
            f_stat_o  = stat;
        end

        pred_pc_d = pred_pc_q;
        halted_d  = halted_q;
        if (rst) begin
            pred_pc_d = '0;
            halted_d  = 1'b0;
        end else if (F_stall_i || eff_halted) begin
            pred_pc_d = pred_pc_q;
            halted_d  = halted_q;
        end else if (!imem.imem_ready_i) begin
            // Latch f_pc so a redirect seen during a wait state is not lost.
            pred_pc_d = f_pc;
            halted_d  = 1'b0;
        end else begin
            pred_pc_d = pred_pc_next;
            halted_d  = (stat != STAT_AOK);
        end
    end

    assign imem.imem_addr_o = f_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_pc_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            pred_pc_q <= pred_pc_d;
            halted_q  <= halted_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage against a small byte memory
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        F_stall_i = 1'b0;
    logic [7:0]  M_icode_i = 8'h0;
    logic        M_Cnd_i = 1'b1;
    logic [31:0] M_valA_i = 32'h0;
    logic [7:0]  W_icode_i = 8'h0;
    logic [31:0] W_valM_i = 32'h0;
    logic        ready = 1'b1;
    logic [7:0]  f_icode_o, f_ifun_o, f_rA_o, f_rB_o, f_dstE_o, f_dstM_o, f_stat_o;
    logic [31:0] f_valC_o, f_valP_o;
    logic [7:0]  mem [0:255];
    logic [47:0] rd_data;
    int          checks = 0;
    int          errors = 0;

    fetch_stage_if ifc ();

    always #5 clk = ~clk;

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < 6; k++) begin
            rd_data[k*8 +: 8] = mem[8'(ifc.imem_addr_o[7:0] + 8'(k))];
        end
    end
    assign ifc.imem_data_i  = rd_data;
    assign ifc.imem_ready_i = ready;

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .F_stall_i (F_stall_i),
        .M_icode_i (M_icode_i),
        .M_Cnd_i   (M_Cnd_i),
        .M_valA_i  (M_valA_i),
        .W_icode_i (W_icode_i),
        .W_valM_i  (W_valM_i),
        .imem      (ifc.master),
        .f_icode_o (f_icode_o),
        .f_ifun_o  (f_ifun_o),
        .f_rA_o    (f_rA_o),
        .f_rB_o    (f_rB_o),
        .f_dstE_o  (f_dstE_o),
        .f_dstM_o  (f_dstM_o),
        .f_stat_o  (f_stat_o),
        .f_valC_o  (f_valC_o),
        .f_valP_o  (f_valP_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_bubble(input string tag, input logic [31:0] valp);
        chk({tag, "_icode"}, 32'(f_icode_o), 32'h1);
        chk({tag, "_ifun"},  32'(f_ifun_o),  32'h0);
        chk({tag, "_rA"},    32'(f_rA_o),    32'hF);
        chk({tag, "_dstE"},  32'(f_dstE_o),  32'hF);
        chk({tag, "_dstM"},  32'(f_dstM_o),  32'hF);
        chk({tag, "_valC"},  f_valC_o,       32'h0);
        chk({tag, "_valP"},  f_valP_o,       valp);
        chk({tag, "_stat"},  32'(f_stat_o),  32'h1);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h10;
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = 48'h30F378563412;
        {mem[6], mem[7], mem[8], mem[9], mem[10]}       = 40'h7010000000;
        {mem[16], mem[17], mem[18], mem[19], mem[20]}   = 40'h7040000000;
        {mem[128], mem[129]}                             = 16'h2012;
        {mem[130], mem[131]}                             = 16'hB03F;
        {mem[132], mem[133], mem[134], mem[135], mem[136], mem[137]} = 48'h501208000000;
        {mem[138], mem[139], mem[140], mem[141], mem[142]} = 40'h8020000000;
        {mem[32], mem[33]}                               = 16'h6012;
        mem[34] = 8'h00;
        mem[48] = 8'hC0;

        next_cycle();
        next_cycle();
        #1;
        chk_bubble("rst", 32'h0);

        rst = 1'b0;
        #1;
        chk("irmovl_pc",    ifc.imem_addr_o, 32'h0);
        chk("irmovl_icode", 32'(f_icode_o), 32'h3);
        chk("irmovl_ifun",  32'(f_ifun_o),  32'h0);
        chk("irmovl_rA",    32'(f_rA_o),    32'hF);
        chk("irmovl_rB",    32'(f_rB_o),    32'h3);
        chk("irmovl_valC",  f_valC_o,       32'h12345678);
        chk("irmovl_valP",  f_valP_o,       32'h6);
        chk("irmovl_dstE",  32'(f_dstE_o),  32'h3);
        chk("irmovl_dstM",  32'(f_dstM_o),  32'hF);
        chk("irmovl_stat",  32'(f_stat_o),  32'h1);

        next_cycle(); #1;
        chk("jmp1_pc",    ifc.imem_addr_o, 32'h6);
        chk("jmp1_icode", 32'(f_icode_o), 32'h7);
        chk("jmp1_valC",  f_valC_o,       32'h10);
        chk("jmp1_valP",  f_valP_o,       32'hB);
        chk("jmp1_dstE",  32'(f_dstE_o),  32'hF);

        next_cycle(); #1;
        chk("jmp2_pc",   ifc.imem_addr_o, 32'h10);
        chk("jmp2_valC", f_valC_o,        32'h40);
        chk("jmp2_valP", f_valP_o,        32'h15);

        next_cycle(); #1;
        chk("pred_pc", ifc.imem_addr_o, 32'h40);

        next_cycle();
        M_icode_i = 8'h07; M_Cnd_i = 1'b0; M_valA_i = 32'h15;
        #1;
        chk("mispred_pc",    ifc.imem_addr_o, 32'h15);
        chk("mispred_icode", 32'(f_icode_o),  32'h1);

        next_cycle();
        M_icode_i = 8'h0; M_Cnd_i = 1'b1;
        #1;
        chk("after_mispred_pc", ifc.imem_addr_o, 32'h16);
        W_icode_i = 8'h09; W_valM_i = 32'h80; ready = 1'b0;
        #1;
        chk("ret_wait_pc", ifc.imem_addr_o, 32'h80);
        chk_bubble("ret_wait", 32'h80);

        next_cycle();
        W_icode_i = 8'h0; ready = 1'b1;
        #1;
        chk("ret_pc",    ifc.imem_addr_o, 32'h80);
        chk("rr_icode",  32'(f_icode_o),  32'h2);
        chk("rr_rA",     32'(f_rA_o),     32'h1);
        chk("rr_dstE",   32'(f_dstE_o),   32'h2);
        chk("rr_valP",   f_valP_o,        32'h82);

        next_cycle(); #1;
        chk("pop_dstE", 32'(f_dstE_o), 32'h4);
        chk("pop_dstM", 32'(f_dstM_o), 32'h3);
        chk("pop_valP", f_valP_o,      32'h84);

        next_cycle(); #1;
        chk("mr_valC", f_valC_o,       32'h8);
        chk("mr_dstE", 32'(f_dstE_o),  32'hF);
        chk("mr_dstM", 32'(f_dstM_o),  32'h1);
        chk("mr_valP", f_valP_o,       32'h8A);

        next_cycle(); #1;
        chk("call_valC", f_valC_o,      32'h20);
        chk("call_dstE", 32'(f_dstE_o), 32'h4);
        chk("call_valP", f_valP_o,      32'h8F);

        next_cycle();
        F_stall_i = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("stall_pc",    ifc.imem_addr_o, 32'h20);
            chk("stall_icode", 32'(f_icode_o),  32'h6);
            chk("stall_valP",  f_valP_o,        32'h22);
            next_cycle(); #1;
        end
        F_stall_i = 1'b0;
        #1;
        chk("unstall_pc", ifc.imem_addr_o, 32'h20);

        next_cycle(); #1;
        chk("halt_pc",    ifc.imem_addr_o, 32'h22);
        chk("halt_icode", 32'(f_icode_o),  32'h0);
        chk("halt_stat",  32'(f_stat_o),   32'h2);
        chk("halt_valP",  f_valP_o,        32'h23);
        chk("halt_dstE",  32'(f_dstE_o),   32'hF);

        next_cycle(); #1;
        chk("halted1_pc", ifc.imem_addr_o, 32'h23);
        chk_bubble("halted1", 32'h23);
        next_cycle(); #1;
        chk_bubble("halted2", 32'h23);

        M_icode_i = 8'h07; M_Cnd_i = 1'b0; M_valA_i = 32'h30;
        #1;
        chk("ins_pc",    ifc.imem_addr_o, 32'h30);
        chk("ins_icode", 32'(f_icode_o),  32'hC);
        chk("ins_stat",  32'(f_stat_o),   32'h4);
        chk("ins_dstE",  32'(f_dstE_o),   32'hF);
        chk("ins_dstM",  32'(f_dstM_o),   32'hF);
        chk("ins_valP",  f_valP_o,        32'h31);

        next_cycle();
        M_icode_i = 8'h0; M_Cnd_i = 1'b1;
        #1;
        chk_bubble("ins_halted", 32'h31);

        rst = 1'b1;
        #1;
        chk_bubble("rst_halted", 32'h0);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("post_rst_pc",    ifc.imem_addr_o, 32'h0);
        chk("post_rst_icode", 32'(f_icode_o),  32'h3);
        chk("post_rst_stat",  32'(f_stat_o),   32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have port F_stall_i, input, 1, the hazard unit's hold request for the fetch register.
REQ-004 The block SHALL have port M_icode_i, input, 8, the memory-stage icode.
REQ-005 The block SHALL have port M_Cnd_i, input, 1, the memory-stage branch-taken flag.
REQ-006 The block SHALL have port M_valA_i, input, 32, the memory-stage fall-through PC of a jXX.
REQ-007 The block SHALL have port W_icode_i, input, 8, the write-back-stage icode.
REQ-008 The block SHALL have port W_valM_i, input, 32, the write-back-stage return address.
REQ-009 The block SHALL have port imem_addr_o, output, 32, the instruction fetch address, equal to f_pc.
REQ-010 The block SHALL have port imem_data_i, input, 48, six instruction bytes from imem_addr_o, byte0 in bits 7:0, combinational read.
REQ-011 The block SHALL have port imem_ready_i, input, 1, asserted when imem_data_i is valid this cycle.
REQ-012 The block SHALL have ports f_icode_o, f_ifun_o, f_rA_o, f_rB_o, f_dstE_o, f_dstM_o, f_stat_o, output, 8 each, the decoded instruction fields feeding the D pipeline register.
REQ-013 The block SHALL have ports f_valC_o and f_valP_o, output, 32 each, the constant word and the next sequential PC.

Function
REQ-014 f_pc SHALL be M_valA_i when M_icode_i==JXX and M_Cnd_i==0; otherwise W_valM_i when W_icode_i==RET; otherwise predPC.
REQ-015 icode SHALL be byte0[7:4] and ifun SHALL be byte0[3:0], each zero-extended to 8 bits.
REQ-016 Register-byte instructions (2,3,4,5,6,A,B) SHALL take rA from byte1[7:4] and rB from byte1[3:0]; all other instructions SHALL drive rA=rB=RNONE (0xF).
REQ-017 valC SHALL be little-endian bytes 2..5 for icodes 3,4,5, little-endian bytes 1..4 for icodes 7,8, and 0 otherwise.
REQ-018 valP SHALL be f_pc + 1 + (register byte ? 1 : 0) + (valC ? 4 : 0), computed modulo 2^32.
REQ-019 dstE SHALL be rB for icodes 2,3,6; ESP (4) for icodes 8,9,A,B; RNONE otherwise.
REQ-020 dstM SHALL be rA for icodes 5,B and RNONE otherwise.
REQ-021 predPC_next SHALL be valC for icodes 7,8 and valP otherwise.
REQ-022 f_stat_o SHALL be AOK=1, HLT=2 for icode 0, and INS=4 for icode >0xB; an INS instruction SHALL force dstE=dstM=RNONE.
REQ-023 A bubble SHALL drive icode=NOP(1), ifun=0, rA=rB=dstE=dstM=RNONE, valC=0, valP=f_pc, stat=AOK.
REQ-024 When F_stall_i=1, predPC SHALL hold and the outputs SHALL follow REQ-014..022; stall SHALL take priority over every other update.
REQ-025 When F_stall_i=0 and imem_ready_i=0, the block SHALL output a bubble and load predPC with f_pc, so a redirect arriving during a wait state is retained.
REQ-026 When F_stall_i=0 and imem_ready_i=1, the block SHALL load predPC with predPC_next.
REQ-027 An accepted fetch with stat HLT or INS SHALL set a halted flag; while halted, the block SHALL output bubbles and hold predPC.
REQ-028 A redirect by REQ-014 (mispredict or ret) SHALL clear halted in the same cycle and resume fetch at the redirect target; a redirect SHALL win over a simultaneous halt fetch.

Reset
REQ-029 While rst=1, predPC SHALL load 0 and halted SHALL clear at the clock edge, and the outputs SHALL be a bubble with valP=0.
REQ-030 A reset asserted mid-wait, mid-stall or while halted SHALL take priority over every other update.

Structure
REQ-031 icode values, register IDs (RNONE, ESP), stat codes and the BYTE/WORD widths SHALL live in the shared defines header.
REQ-032 Byte extraction (icode, ifun, rA, rB, valC) SHALL be one combinational sub-module, fetch_split; PC select, predPC and halted SHALL stay in fetch_stage.

Verification
REQ-033 Reset, then imem at 0 = 30 F3 78 56 34 12 (irmovl): f_icode=3, rB=3, valC=0x12345678, valP=6, dstE=3; next f_pc=6.
REQ-034 jXX at 0x10 with valC=0x40: predPC->0x40; two cycles later M_icode=7, M_Cnd=0, M_valA=0x15 -> f_pc=0x15 that cycle.
REQ-035 ret in W with W_valM=0x80 while imem_ready_i=0: bubble out, predPC=0x80; when ready, fetch at 0x80.
REQ-036 F_stall_i=1 for 3 cycles at PC 0x20: outputs stable, predPC held; release -> advance to valP.
REQ-037 Byte 0x00 fetched: stat=HLT, later outputs are NOP bubbles; byte 0xC0 fetched: stat=INS; then a mispredict redirect clears halted and fetch resumes.
REQ-038 rst pulsed while halted at PC 0x30: next cycle f_pc=0, halted clear.
